chol_dot_seq: RTL and testbench

CHOL_DOT_SEQ -- requirements
Module: chol_dot_seq

---
 rtl/chol_dot_seq.sv | 136 +++++++++++++
 tb/tb_chol_dot_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chol_dot_seq.sv
// -----------------------------------------------------------------------------
// chol_dot_seq
//   Sequences one dot product at a time through an external multiply-accumulate
//   unit. The accumulator is preloaded from init, then each accepted operand
//   pair is presented to the MAC (addend = current accumulator) for
//   MAC_LATENCY+1 enabled cycles. The MAC result is captured back into the
//   accumulator. After len pairs the accumulator is offered as the result.
//   Only one product is in flight at any time.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   start, len, init     request a dot product of len pairs, accumulator seed
//   in_valid, in_ready   operand pair handshake (in_a, in_b signed 32-bit)
//   mac_clken            enable for the downstream MAC pipeline
//   mac_a, mac_b, mac_c  MAC operands; mac_c is the running accumulator
//   mac_out              MAC result a*b+c
//   res_valid, res_ready result handshake, res_data = final accumulator
//   busy                 high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module chol_dot_seq #(
  parameter int MAC_LATENCY = 4,
  parameter int LEN_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  input  logic [63:0]         init,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [31:0]  in_a,
  input  logic signed [31:0]  in_b,
  output logic                mac_clken,
  output logic signed [31:0]  mac_a,
  output logic signed [31:0]  mac_b,
  output logic [63:0]         mac_c,
  input  logic [63:0]         mac_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [63:0]         res_data,
  output logic                busy
);

  localparam int CNT_W = (MAC_LATENCY < 1) ? 1 : $clog2(MAC_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAC_LATENCY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [63:0]         acc_q, acc_d;
  logic signed [31:0]  op_a_q, op_a_d;
  logic signed [31:0]  op_b_q, op_b_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    rem_q, rem_d;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = init;
          if (len != '0) begin
            rem_d   = len;
            state_d = FETCH;
          end else begin
            // Empty product: the seed itself is the result.
            state_d = DONE;
          end
        end
      end
      FETCH: begin
        if (in_valid) begin
          op_a_d  = in_a;
          op_b_d  = in_b;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Operands and accumulator stay frozen so the MAC sees one stable
        // a*b+c for its whole latency; the result lands when cnt hits the end.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          acc_d   = mac_out;
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == LEN_W'(1)) ? DONE : FETCH;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
    end
  end

  // Handshake outputs decode the state register only, so neither in_valid
  // nor res_ready can reach them combinationally.
  assign in_ready  = (state_q == FETCH);
  assign mac_clken = (state_q == WAIT);
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

  assign mac_a    = op_a_q;
  assign mac_b    = op_b_q;
  assign mac_c    = acc_q;
  assign res_data = acc_q;

endmodule

// File: tb/tb_chol_dot_seq.sv
module tb_chol_dot_seq;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [7:0]         len = '0;
  logic [63:0]        init = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [31:0] in_a = '0;
  logic signed [31:0] in_b = '0;
  logic               mac_clken;
  logic signed [31:0] mac_a;
  logic signed [31:0] mac_b;
  logic [63:0]        mac_c;
  logic [63:0]        mac_out;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic [63:0]        res_data;
  logic               busy;

  int n_cmp = 0;
  int n_err = 0;
  int pa[3];
  int pb[3];

  always #5 clk = ~clk;

  chol_dot_seq #(.MAC_LATENCY(4), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .init(init),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_clken(mac_clken), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
    .mac_out(mac_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy)
  );

  // Reference MAC: 4 clock-enabled stages computing a*b+c modulo 2^64.
  logic signed [63:0] xa, xb;
  logic [63:0]        mac_sum;
  logic [63:0]        mp [4];
  assign xa      = mac_a;
  assign xb      = mac_b;
  assign mac_sum = 64'(xa * xb) + mac_c;
  assign mac_out = mp[3];

  initial for (int i = 0; i < 4; i++) mp[i] = '0;

  always @(posedge clk) begin
    if (mac_clken) begin
      mp[0] <= mac_sum;
      mp[1] <= mp[0];
      mp[2] <= mp[1];
      mp[3] <= mp[2];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one cycle; returns at the sample point after that edge.
  task automatic pulse_start(input logic [7:0] l, input logic [63:0] s);
    start = 1'b1;
    len   = l;
    init  = s;
    tick();
    start = 1'b0;
  endtask

  // Feeds pairs from pa/pb whenever in_ready is seen, optionally holding
  // in_valid low for 'gap' ready cycles before each pair. No checking here.
  task automatic drive_pairs(input int gap, output int cyc, output int acc_n,
                             output int bad);
    int hold;
    cyc = 0; acc_n = 0; bad = 0; hold = 0;
    while (res_valid !== 1'b1 && cyc < 200) begin
      if (in_ready === 1'b1 && mac_clken === 1'b1) bad++;
      if (in_ready === 1'b1) begin
        if (hold < gap) begin
          in_valid = 1'b0;
          hold++;
        end else begin
          in_valid = 1'b1;
          in_a = (acc_n < 3) ? pa[acc_n] : 0;
          in_b = (acc_n < 3) ? pb[acc_n] : 0;
          acc_n++;
          hold = 0;
        end
      end else begin
        in_valid = (gap == 0);
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%0b want=0", in_ready); end
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid got=%0b want=0", res_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%0b want=0", busy); end
    n_cmp++; if (mac_clken !== 1'b0) begin n_err++; $display("FAIL reset_mac_clken got=%0b want=0", mac_clken); end
    n_cmp++; if (res_data !== 64'd0) begin n_err++; $display("FAIL reset_res_data got=%0h want=0", res_data); end
    n_cmp++; if (mac_a !== 32'sd0 || mac_b !== 32'sd0) begin n_err++; $display("FAIL reset_mac_ab got=%0h/%0h want=0/0", mac_a, mac_b); end
    n_cmp++; if (mac_c !== 64'd0) begin n_err++; $display("FAIL reset_mac_c got=%0h want=0", mac_c); end
    #3 rst_n = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_reset_idle busy got=%0b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    int cyc, acc_n, bad;
    pa = '{2, 4, -1}; pb = '{3, 5, 7};
    pulse_start(8'd3, 64'd0);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_fetch_entry in_ready got=%0b want=1", in_ready); end
    drive_pairs(0, cyc, acc_n, bad);
    n_cmp++; if (cyc != 18) begin n_err++; $display("FAIL b2b_latency got=%0d want=18", cyc); end
    n_cmp++; if (res_data !== 64'd19) begin n_err++; $display("FAIL b2b_result got=%0d want=19", res_data); end
    n_cmp++; if (acc_n != 3) begin n_err++; $display("FAIL b2b_pairs got=%0d want=3", acc_n); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL b2b_ready_in_wait got=%0d want=0", bad); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL b2b_accept valid/busy got=%0b/%0b want=0/0", res_valid, busy); end
  endtask

  task automatic test_len_zero();
    int saw_ready;
    saw_ready = 0;
    start = 1'b1; len = 8'd0; init = 64'h123;
    if (in_ready === 1'b1) saw_ready++;
    tick();
    start = 1'b0;
    if (in_ready === 1'b1) saw_ready++;
    n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL len0_valid got=%0b want=1", res_valid); end
    n_cmp++; if (res_data !== 64'h123) begin n_err++; $display("FAIL len0_data got=%0h want=123", res_data); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    if (in_ready === 1'b1) saw_ready++;
    n_cmp++; if (saw_ready != 0) begin n_err++; $display("FAIL len0_in_ready got=%0d want=0", saw_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL len0_idle busy got=%0b want=0", busy); end
  endtask

  task automatic test_gaps();
    int cyc, acc_n, bad;
    pa = '{2, 4, -1}; pb = '{3, 5, 7};
    pulse_start(8'd3, 64'd0);
    drive_pairs(3, cyc, acc_n, bad);
    n_cmp++; if (res_data !== 64'd19) begin n_err++; $display("FAIL gap_result got=%0d want=19", res_data); end
    n_cmp++; if (acc_n != 3) begin n_err++; $display("FAIL gap_pairs got=%0d want=3", acc_n); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL gap_ready_in_wait got=%0d want=0", bad); end
    n_cmp++; if (cyc != 27) begin n_err++; $display("FAIL gap_latency got=%0d want=27", cyc); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_done_hold();
    int cyc, acc_n, bad, drift;
    pa = '{6, 0, 0}; pb = '{7, 0, 0};
    pulse_start(8'd1, 64'd10);
    drive_pairs(0, cyc, acc_n, bad);
    n_cmp++; if (res_data !== 64'd52) begin n_err++; $display("FAIL hold_result got=%0d want=52", res_data); end
    drift = 0;
    for (int k = 0; k < 10; k++) begin
      start = (k == 3);
      len   = 8'd5;
      init  = 64'd999;
      tick();
      if (res_valid !== 1'b1 || res_data !== 64'd52 || in_ready !== 1'b0) drift++;
    end
    start = 1'b0;
    n_cmp++; if (drift != 0) begin n_err++; $display("FAIL hold_stable got=%0d changes want=0", drift); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL hold_to_idle valid/busy got=%0b/%0b want=0/0", res_valid, busy); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL hold_start_ignored busy got=%0b want=0", busy); end
  endtask

  task automatic test_reset_mid();
    int cyc, acc_n, bad, n;
    pa = '{2, 4, -1}; pb = '{3, 5, 7};
    n = 0;
    pulse_start(8'd3, 64'd0);
    for (int k = 0; k < 8; k++) begin
      if (in_ready === 1'b1 && n < 3) begin
        in_valid = 1'b1; in_a = pa[n]; in_b = pb[n]; n++;
      end
      tick();
    end
    in_valid = 1'b1;
    n_cmp++; if (mac_clken !== 1'b1 || n != 2) begin n_err++; $display("FAIL mid_in_wait clken/pairs got=%0b/%0d want=1/2", mac_clken, n); end
    n_cmp++; if (mac_a !== 32'sd4 || mac_b !== 32'sd5) begin n_err++; $display("FAIL mid_mac_ab got=%0d/%0d want=4/5", mac_a, mac_b); end
    n_cmp++; if (mac_c !== 64'd6) begin n_err++; $display("FAIL mid_mac_c got=%0d want=6", mac_c); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({in_ready, res_valid, busy, mac_clken} !== 4'b0) begin n_err++; $display("FAIL mid_async_ctrl got=%b want=0000", {in_ready, res_valid, busy, mac_clken}); end
    n_cmp++; if (res_data !== 64'd0 || mac_c !== 64'd0) begin n_err++; $display("FAIL mid_async_data got=%0h/%0h want=0/0", res_data, mac_c); end
    n_cmp++; if (mac_a !== 32'sd0 || mac_b !== 32'sd0) begin n_err++; $display("FAIL mid_async_ab got=%0h/%0h want=0/0", mac_a, mac_b); end
    in_valid = 1'b0;
    tick();
    #3 rst_n = 1'b1;
    tick();
    pa = '{3, 0, 0}; pb = '{3, 0, 0};
    pulse_start(8'd1, 64'd5);
    drive_pairs(0, cyc, acc_n, bad);
    n_cmp++; if (res_data !== 64'd14) begin n_err++; $display("FAIL mid_restart_result got=%0d want=14", res_data); end
    n_cmp++; if (cyc != 6) begin n_err++; $display("FAIL mid_restart_latency got=%0d want=6", cyc); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int cyc, acc_n, bad;
    pa = '{1, 0, 0}; pb = '{1, 0, 0};
    pulse_start(8'd1, 64'h7FFF_FFFF_FFFF_FFFF);
    drive_pairs(0, cyc, acc_n, bad);
    n_cmp++; if (res_data !== 64'h8000_0000_0000_0000) begin n_err++; $display("FAIL wrap_pos got=%0h want=8000000000000000", res_data); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    pa = '{-1, 0, 0}; pb = '{1, 0, 0};
    pulse_start(8'd1, 64'd0);
    drive_pairs(0, cyc, acc_n, bad);
    n_cmp++; if (res_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL wrap_neg got=%0h want=ffffffffffffffff", res_data); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_len_zero();
    test_gaps();
    test_done_hold();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
